full_adder: RTL and testbench

- Registered full adder; the 1-bit default is the arithmetic primitive for the adder datapath.
- Adds operands a and b and carry-in c.
- Registers the sum s and carry-out cr on the rising clock edge.
- Built as a ripple chain of 1-bit cells. Each cell is two half adders plus an OR, using the shared gate-level library (nand/not/and/or/xor/halfadder) rather than the `+` operator.

---
 rtl/full_adder.sv | 145 ++++++++++++++
 tb/tb_full_adder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/full_adder.sv
// Registered ripple-carry adder: {cr, s} <= a + b + c on each rising clk edge.
// The chain is built from 1-bit full-adder cells, each made of two half adders
// and an OR, all reduced to NAND/NOT primitives from the gate library below.
module full_adder #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic [WIDTH-1:0] s,
    output logic             cr
);

    // Ripple carry: k[0] is the carry-in, k[WIDTH] becomes the carry-out.
    logic [WIDTH:0]   k;
    logic [WIDTH-1:0] sum_p0;

    assign k[0] = c;

    // Stage p0: purely combinational ripple chain feeding the output registers.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        fa_cell u_cell (
            .a   (a[i]),
            .b   (b[i]),
            .k   (k[i]),
            .sum (sum_p0[i]),
            .co  (k[i+1])
        );
    end

    // Capture the chain result; synchronous reset clears both outputs and wins over data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s  <= '0;
            cr <= 1'b0;
        end else begin
            s  <= sum_p0;
            cr <= k[WIDTH];
        end
    end

endmodule

// One full-adder cell: two cascaded half adders, carries merged with an OR.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic k,
    output logic sum,
    output logic co
);

    logic p;
    logic g1;
    logic g2;

    half_adder u_ha1 (.a(a), .b(b), .s(p),   .g(g1));
    half_adder u_ha2 (.a(p), .b(k), .s(sum), .g(g2));
    or2        u_or  (.a(g1), .b(g2), .y(co));

endmodule

// Half adder: propagate/sum via XOR, generate via AND.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic g
);

    xor2 u_xor (.a(a), .b(b), .y(s));
    and2 u_and (.a(a), .b(b), .y(g));

endmodule

// XOR in the classic four-NAND arrangement.
module xor2 (
    input  logic a,
    input  logic b,
    output logic y
);

    logic n1;
    logic n2;
    logic n3;

    nand2 u_n1 (.a(a),  .b(b),  .y(n1));
    nand2 u_n2 (.a(a),  .b(n1), .y(n2));
    nand2 u_n3 (.a(b),  .b(n1), .y(n3));
    nand2 u_n4 (.a(n2), .b(n3), .y(y));

endmodule

// AND as NAND followed by an inverter.
module and2 (
    input  logic a,
    input  logic b,
    output logic y
);

    logic n;

    nand2 u_nand (.a(a), .b(b), .y(n));
    inv   u_inv  (.a(n), .y(y));

endmodule

// OR by De Morgan: NAND of the inverted inputs.
module or2 (
    input  logic a,
    input  logic b,
    output logic y
);

    logic na;
    logic nb;

    inv   u_inva (.a(a), .y(na));
    inv   u_invb (.a(b), .y(nb));
    nand2 u_nand (.a(na), .b(nb), .y(y));

endmodule

// Base primitive: 2-input NAND.
module nand2 (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = ~(a & b);

endmodule

// Base primitive: inverter.
module inv (
    input  logic a,
    output logic y
);

    assign y = ~a;

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder: a 1-bit and a 4-bit instance share clock and reset.
// Expected values come from plain integer addition of the applied operands.
module tb_full_adder;

    logic       clk;
    logic       rst_n;
    logic       a1, b1, c1;
    logic       s1, cr1;
    logic [3:0] a4, b4;
    logic       c4;
    logic [3:0] s4;
    logic       cr4;

    int checks;
    int errors;

    full_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .c(c1), .s(s1), .cr(cr1)
    );

    full_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .c(c4), .s(s4), .cr(cr4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
        a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({cr1, s1} !== 2'b00) begin
                errors++;
                $display("FAIL reset_w1 cycle %0d: got cr=%b s=%b, want cr=0 s=0", i, cr1, s1);
            end
            checks++;
            if ({cr4, s4} !== 5'b0) begin
                errors++;
                $display("FAIL reset_w4 cycle %0d: got cr=%b s=%0d, want cr=0 s=0", i, cr4, s4);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_sweep();
        int exp;
        for (int v = 0; v < 8; v++) begin
            a1 = v[2]; b1 = v[1]; c1 = v[0];
            exp = int'(a1) + int'(b1) + int'(c1);
            tick();
            checks++;
            if (s1 !== exp[0] || cr1 !== exp[1]) begin
                errors++;
                $display("FAIL sweep abc=%0d%0d%0d: got cr=%b s=%b, want cr=%0d s=%0d",
                         v[2], v[1], v[0], cr1, s1, exp[1], exp[0]);
            end
        end
    endtask

    task automatic test_hold();
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({cr1, s1} !== 2'b10) begin
                errors++;
                $display("FAIL hold cycle %0d: got cr=%b s=%b, want cr=1 s=0", i, cr1, s1);
            end
            // Wiggle inputs between edges; registered outputs must not follow.
            a1 = 1'b0; b1 = 1'b0; c1 = 1'b1;
            #2;
            checks++;
            if ({cr1, s1} !== 2'b10) begin
                errors++;
                $display("FAIL hold_glitch cycle %0d: got cr=%b s=%b, want cr=1 s=0", i, cr1, s1);
            end
            a1 = 1'b1; b1 = 1'b1; c1 = 1'b0;
        end
    endtask

    task automatic test_mid_reset();
        a1 = 1'b1; b1 = 1'b0; c1 = 1'b1;
        tick();
        checks++;
        if ({cr1, s1} !== 2'b10) begin
            errors++;
            $display("FAIL midrst_pre: got cr=%b s=%b, want cr=1 s=0", cr1, s1);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if ({cr1, s1} !== 2'b00) begin
            errors++;
            $display("FAIL midrst_in_reset: got cr=%b s=%b, want cr=0 s=0", cr1, s1);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if ({cr1, s1} !== 2'b10) begin
            errors++;
            $display("FAIL midrst_after_release: got cr=%b s=%b, want cr=1 s=0", cr1, s1);
        end
    endtask

    task automatic test_overflow();
        int vec_a [3] = '{15, 15, 5};
        int vec_b [3] = '{1, 15, 6};
        int vec_c [3] = '{0, 1, 1};
        int want_s [3] = '{0, 15, 12};
        int want_c [3] = '{1, 1, 0};
        for (int i = 0; i < 3; i++) begin
            a4 = 4'(vec_a[i]); b4 = 4'(vec_b[i]); c4 = 1'(vec_c[i]);
            tick();
            checks++;
            if (int'(s4) !== want_s[i] || int'(cr4) !== want_c[i]) begin
                errors++;
                $display("FAIL overflow %0d+%0d+%0d: got cr=%b s=%0d, want cr=%0d s=%0d",
                         vec_a[i], vec_b[i], vec_c[i], cr4, s4, want_c[i], want_s[i]);
            end
        end
        // Zero operands.
        a4 = 4'd0; b4 = 4'd0; c4 = 1'b0;
        tick();
        checks++;
        if ({cr4, s4} !== 5'b0) begin
            errors++;
            $display("FAIL zero_w4: got cr=%b s=%0d, want cr=0 s=0", cr4, s4);
        end
    endtask

    task automatic test_random();
        int q[$];
        int got;
        int want;
        for (int i = 0; i < 1000; i++) begin
            a4 = 4'($urandom_range(0, 15));
            b4 = 4'($urandom_range(0, 15));
            c4 = 1'($urandom_range(0, 1));
            q.push_back(int'(a4) + int'(b4) + int'(c4));
            tick();
            want = q.pop_front();
            got  = int'({cr4, s4});
            checks++;
            if (got !== want || $isunknown({cr4, s4})) begin
                errors++;
                $display("FAIL random cycle %0d: got {cr,s}=%0d, want %0d", i, got, want);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
        a4 = 4'd0; b4 = 4'd0; c4 = 1'b0;
        test_reset();
        test_sweep();
        test_hold();
        test_mid_reset();
        test_overflow();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
